// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - signal bundle between the pipeline stage registers and pipe_hazard_ctrl
//
// Purpose: groups the decode/stage information presented to the hazard controller
//          and the pipeline controls and counters it returns.
// Ports (slave = controller view):
//   i_fetch_valid                      IF presents a real instruction
//   i_id_rs/i_id_rt/i_id_uses_rs/rt    sources of the IF/ID instruction
//   i_id_jump                          IF/ID instruction is a jump
//   i_ex_rs/i_ex_rt                    sources of the ID/EX instruction
//   i_ex_rd/i_ex_reg_write/i_ex_mem_read  ID/EX destination info
//   i_dm_rd/i_dm_reg_write             EX/DM destination info
//   i_wb_rd/i_wb_reg_write             DM/WB destination info
//   i_branch_taken                     branch in the resolving register is taken
//   i_cnt_clr                          synchronous counter clear
//   o_stage_valid[3:0]                 valid bits IF/ID, ID/EX, EX/DM, DM/WB
//   o_pc_stall/o_if_id_stall/o_id_ex_bubble  load-use controls
//   o_flush[3:0]                       per-register flush
//   o_pc_sel                           00 PC+4, 01 jump, 10 branch
//   o_fwd_a/o_fwd_b                    00 regfile, 10 EX/DM, 01 DM/WB
//   o_stall_cnt/o_flush_cnt/o_retired_cnt  saturating performance counters
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  i_fetch_valid;
  logic [REG_ADDR_W-1:0] i_id_rs;
  logic [REG_ADDR_W-1:0] i_id_rt;
  logic                  i_id_uses_rs;
  logic                  i_id_uses_rt;
  logic                  i_id_jump;
  logic [REG_ADDR_W-1:0] i_ex_rs;
  logic [REG_ADDR_W-1:0] i_ex_rt;
  logic [REG_ADDR_W-1:0] i_ex_rd;
  logic                  i_ex_reg_write;
  logic                  i_ex_mem_read;
  logic [REG_ADDR_W-1:0] i_dm_rd;
  logic                  i_dm_reg_write;
  logic [REG_ADDR_W-1:0] i_wb_rd;
  logic                  i_wb_reg_write;
  logic                  i_branch_taken;
  logic                  i_cnt_clr;

  logic [3:0]            o_stage_valid;
  logic                  o_pc_stall;
  logic                  o_if_id_stall;
  logic                  o_id_ex_bubble;
  logic [3:0]            o_flush;
  logic [1:0]            o_pc_sel;
  logic [1:0]            o_fwd_a;
  logic [1:0]            o_fwd_b;
  logic [CNT_W-1:0]      o_stall_cnt;
  logic [CNT_W-1:0]      o_flush_cnt;
  logic [CNT_W-1:0]      o_retired_cnt;

  modport master (
    output i_fetch_valid, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt, i_id_jump,
    output i_ex_rs, i_ex_rt, i_ex_rd, i_ex_reg_write, i_ex_mem_read,
    output i_dm_rd, i_dm_reg_write, i_wb_rd, i_wb_reg_write,
    output i_branch_taken, i_cnt_clr,
    input  o_stage_valid, o_pc_stall, o_if_id_stall, o_id_ex_bubble, o_flush,
    input  o_pc_sel, o_fwd_a, o_fwd_b, o_stall_cnt, o_flush_cnt, o_retired_cnt
  );

  modport slave (
    input  i_fetch_valid, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt, i_id_jump,
    input  i_ex_rs, i_ex_rt, i_ex_rd, i_ex_reg_write, i_ex_mem_read,
    input  i_dm_rd, i_dm_reg_write, i_wb_rd, i_wb_reg_write,
    input  i_branch_taken, i_cnt_clr,
    output o_stage_valid, o_pc_stall, o_if_id_stall, o_id_ex_bubble, o_flush,
    output o_pc_sel, o_fwd_a, o_fwd_b, o_stall_cnt, o_flush_cnt, o_retired_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, forwarding and stage-validity controller for the 5-stage MIPS pipeline
//
// Purpose: tracks a valid bit per inter-stage register, detects load-use hazards,
//          issues flushes/redirects for jumps (ID) and branches (EX or DM),
//          selects EX operand forwarding and keeps saturating perf counters.
// Ports:
//   i_clk    clock, all state on the rising edge
//   i_reset  asynchronous active-low reset, clears valid bits and counters
//   bus      pipe_hazard_ctrl_if.slave, see the interface file for signal list
// Parameters:
//   REG_ADDR_W    register address width
//   BRANCH_STAGE  2 = branch resolved from ID/EX, 3 = from EX/DM
//   CNT_W         performance counter width
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int BRANCH_STAGE = 2,
  parameter int CNT_W        = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
  // A taken branch kills every register younger than itself.
  localparam logic [3:0] BR_FLUSH_MASK = (BRANCH_STAGE == 3) ? 4'b0111 : 4'b0011;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       r_v;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_retired_cnt;

  logic       w_dm_writer;
  logic       w_wb_writer;
  logic       w_lu_rs;
  logic       w_lu_rt;
  logic       w_lu;
  logic       w_br;
  logic       w_jp;
  logic [3:0] w_flush;
  logic [1:0] w_pc_sel;
  logic       w_stall;
  logic [3:0] w_v_next;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Writers further down the pipe only count when their register holds a real
  // instruction; register 0 is hard-wired so it is never a forwarding source.
  assign w_dm_writer = r_v[2] & bus.i_dm_reg_write & (bus.i_dm_rd != ZERO_REG);
  assign w_wb_writer = r_v[3] & bus.i_wb_reg_write & (bus.i_wb_rd != ZERO_REG);

  assign w_lu_rs = bus.i_id_uses_rs & (bus.i_id_rs == bus.i_ex_rd);
  assign w_lu_rt = bus.i_id_uses_rt & (bus.i_id_rt == bus.i_ex_rd);
  assign w_lu    = r_v[0] & r_v[1] & bus.i_ex_mem_read & (bus.i_ex_rd != ZERO_REG)
                 & (w_lu_rs | w_lu_rt);

  assign w_br = r_v[BRANCH_STAGE-1] & bus.i_branch_taken;
  // A jump stuck behind a load-use stall waits; it redirects once the stall clears.
  assign w_jp = r_v[0] & bus.i_id_jump & ~w_lu;

  // Priority: branch > load-use > jump.
  always_comb begin
    w_flush  = 4'b0000;
    w_pc_sel = 2'b00;
    w_stall  = 1'b0;
    if (w_br) begin
      w_flush  = BR_FLUSH_MASK;
      w_pc_sel = 2'b10;
    end else if (w_lu) begin
      w_stall  = 1'b1;
    end else if (w_jp) begin
      w_flush  = 4'b0001;
      w_pc_sel = 2'b01;
    end
  end

  always_comb begin
    w_v_next    = 4'b0000;
    w_v_next[3] = r_v[2];
    // With the branch in ID/EX, flush[1] names the branch itself, which still advances.
    if (w_br && (BRANCH_STAGE == 2)) begin
      w_v_next[2] = r_v[1];
    end else begin
      w_v_next[2] = r_v[1] & ~w_flush[1];
    end
    w_v_next[1] = r_v[0] & ~w_flush[0] & ~w_lu;
    if (w_flush[0]) begin
      w_v_next[0] = 1'b0;
    end else if (w_lu) begin
      w_v_next[0] = r_v[0];
    end else begin
      w_v_next[0] = bus.i_fetch_valid;
    end
  end

  // EX/DM holds the younger result, so it wins over DM/WB.
  always_comb begin
    w_fwd_a = 2'b00;
    if (w_dm_writer && (bus.i_dm_rd == bus.i_ex_rs)) begin
      w_fwd_a = 2'b10;
    end else if (w_wb_writer && (bus.i_wb_rd == bus.i_ex_rs)) begin
      w_fwd_a = 2'b01;
    end
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (w_dm_writer && (bus.i_dm_rd == bus.i_ex_rt)) begin
      w_fwd_b = 2'b10;
    end else if (w_wb_writer && (bus.i_wb_rd == bus.i_ex_rt)) begin
      w_fwd_b = 2'b01;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (cnt != CNT_MAX)) begin
      return cnt + CNT_ONE;
    end
    return cnt;
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_v <= 4'b0000;
    end else begin
      r_v <= w_v_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_retired_cnt <= '0;
    end else if (bus.i_cnt_clr) begin
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      r_stall_cnt   <= sat_inc(r_stall_cnt, w_lu & ~w_br);
      r_flush_cnt   <= sat_inc(r_flush_cnt, w_br | w_jp);
      r_retired_cnt <= sat_inc(r_retired_cnt, r_v[3]);
    end
  end

  assign bus.o_stage_valid  = r_v;
  assign bus.o_pc_stall     = w_stall;
  assign bus.o_if_id_stall  = w_stall;
  assign bus.o_id_ex_bubble = w_stall;
  assign bus.o_flush        = w_flush;
  assign bus.o_pc_sel       = w_pc_sel;
  assign bus.o_fwd_a        = w_fwd_a;
  assign bus.o_fwd_b        = w_fwd_b;
  assign bus.o_stall_cnt    = r_stall_cnt;
  assign bus.o_flush_cnt    = r_flush_cnt;
  assign bus.o_retired_cnt  = r_retired_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl (BRANCH_STAGE 2/16-bit and 3/4-bit)
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic       fv;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       jump;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;
    logic       ex_w;
    logic       ex_mr;
    logic [4:0] dm_rd;
    logic       dm_w;
    logic [4:0] wb_rd;
    logic       wb_w;
    logic       taken;
    logic       clr;
  } in_t;

  typedef struct {
    string name;
    in_t   in;
    int    pc_sel;
    int    flush2;
    int    flush3;
    int    stall;
    int    fwd_a;
    int    fwd_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus2 ();
  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  bus3 ();

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_STAGE(2), .CNT_W(16)) u_dut2 (
    .i_clk(clk), .i_reset(rst_n), .bus(bus2.slave));
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_STAGE(3), .CNT_W(4)) u_dut3 (
    .i_clk(clk), .i_reset(rst_n), .bus(bus3.slave));

  assign bus3.i_fetch_valid  = bus2.i_fetch_valid;
  assign bus3.i_id_rs        = bus2.i_id_rs;
  assign bus3.i_id_rt        = bus2.i_id_rt;
  assign bus3.i_id_uses_rs   = bus2.i_id_uses_rs;
  assign bus3.i_id_uses_rt   = bus2.i_id_uses_rt;
  assign bus3.i_id_jump      = bus2.i_id_jump;
  assign bus3.i_ex_rs        = bus2.i_ex_rs;
  assign bus3.i_ex_rt        = bus2.i_ex_rt;
  assign bus3.i_ex_rd        = bus2.i_ex_rd;
  assign bus3.i_ex_reg_write = bus2.i_ex_reg_write;
  assign bus3.i_ex_mem_read  = bus2.i_ex_mem_read;
  assign bus3.i_dm_rd        = bus2.i_dm_rd;
  assign bus3.i_dm_reg_write = bus2.i_dm_reg_write;
  assign bus3.i_wb_rd        = bus2.i_wb_rd;
  assign bus3.i_wb_reg_write = bus2.i_wb_reg_write;
  assign bus3.i_branch_taken = bus2.i_branch_taken;
  assign bus3.i_cnt_clr      = bus2.i_cnt_clr;

  task automatic drive(input in_t x);
    bus2.i_fetch_valid  = x.fv;
    bus2.i_id_rs        = x.id_rs;
    bus2.i_id_rt        = x.id_rt;
    bus2.i_id_uses_rs   = x.uses_rs;
    bus2.i_id_uses_rt   = x.uses_rt;
    bus2.i_id_jump      = x.jump;
    bus2.i_ex_rs        = x.ex_rs;
    bus2.i_ex_rt        = x.ex_rt;
    bus2.i_ex_rd        = x.ex_rd;
    bus2.i_ex_reg_write = x.ex_w;
    bus2.i_ex_mem_read  = x.ex_mr;
    bus2.i_dm_rd        = x.dm_rd;
    bus2.i_dm_reg_write = x.dm_w;
    bus2.i_wb_rd        = x.wb_rd;
    bus2.i_wb_reg_write = x.wb_w;
    bus2.i_branch_taken = x.taken;
    bus2.i_cnt_clr      = x.clr;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int stall3(input int c);
    if (c == 0) return int'({bus2.o_pc_stall, bus2.o_if_id_stall, bus2.o_id_ex_bubble});
    return int'({bus3.o_pc_stall, bus3.o_if_id_stall, bus3.o_id_ex_bubble});
  endfunction

  in_t Z;
  in_t x;
  vec_t vecs[$];

  task automatic do_reset();
    drive(Z);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic fill();
    in_t f;
    do_reset();
    f = Z;
    f.fv = 1'b1;
    drive(f);
    repeat (4) tick();
  endtask

  task automatic add_vec(input string nm, input in_t i, input int sel, input int f2, input int f3,
                         input int st, input int fa, input int fb);
    vec_t v;
    v.name = nm; v.in = i; v.pc_sel = sel; v.flush2 = f2; v.flush3 = f3;
    v.stall = st; v.fwd_a = fa; v.fwd_b = fb;
    vecs.push_back(v);
  endtask

  // Reference model state: valid bits per instance and counters as plain integers.
  int mv[2][4];
  int nv[2][4];
  int msc[2], mfc[2], mrc[2];

  function automatic int fwd_model(input int c, input logic [4:0] src, input in_t i);
    if (src == 5'd0) return 0;
    if (mv[c][2] != 0 && i.dm_w && i.dm_rd == src) return 2;
    if (mv[c][3] != 0 && i.wb_w && i.wb_rd == src) return 1;
    return 0;
  endfunction

  initial begin
    Z = '{default: 0};
    drive(Z);

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("reset v2", int'(bus2.o_stage_valid), 0);
    chk("reset v3", int'(bus3.o_stage_valid), 0);
    chk("reset cnt", int'(bus2.o_stall_cnt) + int'(bus2.o_flush_cnt) + int'(bus2.o_retired_cnt), 0);
    chk("reset pc_sel", int'(bus2.o_pc_sel), 0);
    #10 rst_n = 1'b1;

    // Table-driven single-cycle scenarios on a full pipeline
    x = Z; x.fv = 1;                                                add_vec("idle", x, 0, 0, 0, 0, 0, 0);
    x = Z; x.fv = 1; x.ex_rs = 3; x.dm_rd = 3; x.dm_w = 1; x.wb_rd = 3; x.wb_w = 1;
                                                                    add_vec("fwd dm wins", x, 0, 0, 0, 0, 2, 0);
    x = Z; x.fv = 1; x.dm_w = 1; x.wb_w = 1;                        add_vec("fwd r0", x, 0, 0, 0, 0, 0, 0);
    x = Z; x.fv = 1; x.ex_rt = 7; x.wb_rd = 7; x.wb_w = 1;          add_vec("fwd wb b", x, 0, 0, 0, 0, 0, 1);
    x = Z; x.fv = 1; x.ex_rs = 4; x.ex_rt = 5; x.dm_rd = 4; x.dm_w = 1; x.wb_rd = 5; x.wb_w = 1;
                                                                    add_vec("fwd both", x, 0, 0, 0, 0, 2, 1);
    x = Z; x.fv = 1; x.ex_rs = 6; x.dm_rd = 6; x.wb_rd = 6; x.wb_w = 1;
                                                                    add_vec("fwd dm nowrite", x, 0, 0, 0, 0, 1, 0);
    x = Z; x.fv = 1; x.ex_mr = 1; x.ex_w = 1; x.ex_rd = 2; x.id_rs = 2; x.uses_rs = 1;
                                                                    add_vec("lu rs", x, 0, 0, 0, 7, 0, 0);
    x.uses_rs = 0;                                                  add_vec("lu unused", x, 0, 0, 0, 0, 0, 0);
    x.id_rt = 2; x.uses_rt = 1;                                     add_vec("lu rt", x, 0, 0, 0, 7, 0, 0);
    x = Z; x.fv = 1; x.ex_mr = 1; x.uses_rs = 1;                    add_vec("lu r0", x, 0, 0, 0, 0, 0, 0);
    x = Z; x.fv = 1; x.taken = 1;                                   add_vec("branch", x, 2, 3, 7, 0, 0, 0);
    x.ex_mr = 1; x.ex_rd = 2; x.id_rs = 2; x.uses_rs = 1;           add_vec("branch+lu", x, 2, 3, 7, 0, 0, 0);
    x = Z; x.fv = 1; x.jump = 1;                                    add_vec("jump", x, 1, 1, 1, 0, 0, 0);
    x.ex_mr = 1; x.ex_rd = 2; x.id_rs = 2; x.uses_rs = 1;           add_vec("jump+lu", x, 0, 0, 0, 7, 0, 0);
    x.taken = 1;                                                    add_vec("jump+lu+br", x, 2, 3, 7, 0, 0, 0);

    foreach (vecs[k]) begin
      fill();
      drive(vecs[k].in);
      #2;
      chk({vecs[k].name, " pc_sel2"}, int'(bus2.o_pc_sel), vecs[k].pc_sel);
      chk({vecs[k].name, " pc_sel3"}, int'(bus3.o_pc_sel), vecs[k].pc_sel);
      chk({vecs[k].name, " flush2"}, int'(bus2.o_flush), vecs[k].flush2);
      chk({vecs[k].name, " flush3"}, int'(bus3.o_flush), vecs[k].flush3);
      chk({vecs[k].name, " stall2"}, stall3(0), vecs[k].stall);
      chk({vecs[k].name, " stall3"}, stall3(1), vecs[k].stall);
      chk({vecs[k].name, " fwd_a"}, int'(bus2.o_fwd_a), vecs[k].fwd_a);
      chk({vecs[k].name, " fwd_b"}, int'(bus2.o_fwd_b), vecs[k].fwd_b);
    end

    // Asynchronous reset mid-run, then refill; an empty pipeline ignores stale fields
    do_reset();
    x = Z; x.fv = 1;
    drive(x);
    repeat (8) tick();
    chk("pre-reset retired", int'(bus2.o_retired_cnt), 4);
    chk("pre-reset v", int'(bus2.o_stage_valid), 15);
    x.taken = 1; x.jump = 1; x.ex_mr = 1; x.ex_rd = 2; x.id_rs = 2; x.uses_rs = 1;
    x.ex_rs = 3; x.dm_rd = 3; x.dm_w = 1; x.wb_rd = 3; x.wb_w = 1;
    drive(x);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst v2", int'(bus2.o_stage_valid), 0);
    chk("async rst v3", int'(bus3.o_stage_valid), 0);
    chk("async rst retired", int'(bus2.o_retired_cnt), 0);
    chk("empty pc_sel", int'(bus2.o_pc_sel), 0);
    chk("empty flush", int'(bus3.o_flush), 0);
    chk("empty stall", stall3(0), 0);
    chk("empty fwd", int'({bus2.o_fwd_a, bus2.o_fwd_b}), 0);
    x = Z; x.fv = 1;
    drive(x);
    #1 rst_n = 1'b1;
    tick(); chk("refill 1", int'(bus2.o_stage_valid), 1);
    tick(); chk("refill 2", int'(bus2.o_stage_valid), 3);
    tick(); chk("refill 3", int'(bus2.o_stage_valid), 7);
    tick(); chk("refill 4", int'(bus3.o_stage_valid), 15);

    // Load-use: one bubble, then DM/WB forwarding into the dependent instruction
    fill();
    x = Z; x.fv = 1; x.ex_mr = 1; x.ex_w = 1; x.ex_rd = 2; x.id_rs = 2; x.uses_rs = 1;
    drive(x); #2;
    chk("lu seq stall", stall3(0), 7);
    tick();
    x = Z; x.fv = 1; x.dm_rd = 2; x.dm_w = 1;
    drive(x); #2;
    chk("lu seq stall_cnt", int'(bus2.o_stall_cnt), 1);
    chk("lu seq v after", int'(bus2.o_stage_valid), 13);
    chk("lu seq no 2nd stall", stall3(0), 0);
    tick();
    x = Z; x.fv = 1; x.ex_rs = 2; x.wb_rd = 2; x.wb_w = 1; x.dm_rd = 2; x.dm_w = 1;
    drive(x); #2;
    chk("lu seq v fwd", int'(bus2.o_stage_valid), 11);
    chk("lu seq fwd_a", int'(bus2.o_fwd_a), 1);

    // Jump held in IF/ID during a load-use: stall first, exactly one redirect after
    fill();
    x = Z; x.fv = 1; x.jump = 1; x.ex_mr = 1; x.ex_rd = 2; x.id_rs = 2; x.uses_rs = 1;
    drive(x); #2;
    chk("jlu stall", stall3(0), 7);
    chk("jlu pc_sel first", int'(bus2.o_pc_sel), 0);
    tick(); #1;
    chk("jlu pc_sel jump", int'(bus2.o_pc_sel), 1);
    chk("jlu flush jump", int'(bus2.o_flush), 1);
    chk("jlu no stall", stall3(0), 0);
    tick(); #1;
    chk("jlu pc_sel after", int'(bus2.o_pc_sel), 0);
    chk("jlu v after", int'(bus2.o_stage_valid), 8);
    chk("jlu flush_cnt", int'(bus2.o_flush_cnt), 1);
    chk("jlu stall_cnt", int'(bus2.o_stall_cnt), 1);

    // Branch and load-use together: flush only, and the resulting valid bits
    fill();
    x = Z; x.fv = 1; x.taken = 1; x.ex_mr = 1; x.ex_rd = 2; x.id_rs = 2; x.uses_rs = 1;
    drive(x);
    tick();
    x = Z; drive(x); #1;
    chk("brlu flush_cnt2", int'(bus2.o_flush_cnt), 1);
    chk("brlu flush_cnt3", int'(bus3.o_flush_cnt), 1);
    chk("brlu stall_cnt2", int'(bus2.o_stall_cnt), 0);
    chk("brlu v2", int'(bus2.o_stage_valid), 12);
    chk("brlu v3", int'(bus3.o_stage_valid), 8);

    // Saturation and clear precedence
    do_reset();
    x = Z; x.fv = 1;
    drive(x);
    repeat (30) tick();
    chk("retired 16b", int'(bus2.o_retired_cnt), 26);
    chk("retired 4b sat", int'(bus3.o_retired_cnt), 15);
    x.clr = 1; drive(x);
    tick();
    chk("clr wins 16b", int'(bus2.o_retired_cnt), 0);
    chk("clr wins 4b", int'(bus3.o_retired_cnt), 0);
    x.clr = 0; drive(x);
    tick();
    chk("after clr", int'(bus3.o_retired_cnt), 1);

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) mv[c][k] = 0;
      msc[c] = 0; mfc[c] = 0; mrc[c] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      x.fv      = ($urandom_range(0, 9) < 8);
      x.id_rs   = 5'($urandom_range(0, 3));
      x.id_rt   = 5'($urandom_range(0, 3));
      x.uses_rs = 1'($urandom_range(0, 1));
      x.uses_rt = 1'($urandom_range(0, 1));
      x.jump    = ($urandom_range(0, 4) == 0);
      x.ex_rs   = 5'($urandom_range(0, 3));
      x.ex_rt   = 5'($urandom_range(0, 3));
      x.ex_rd   = 5'($urandom_range(0, 3));
      x.ex_w    = 1'($urandom_range(0, 1));
      x.ex_mr   = ($urandom_range(0, 2) == 0);
      x.dm_rd   = 5'($urandom_range(0, 3));
      x.dm_w    = 1'($urandom_range(0, 1));
      x.wb_rd   = 5'($urandom_range(0, 3));
      x.wb_w    = 1'($urandom_range(0, 1));
      x.taken   = ($urandom_range(0, 4) == 0);
      x.clr     = ($urandom_range(0, 49) == 0);
      drive(x);
      #2;
      for (int c = 0; c < 2; c++) begin
        int bs, cmax, e_sel, e_fl, e_st;
        int a_v, a_sel, a_fl, a_fa, a_fb, a_sc, a_fc, a_rc;
        bit lu, br, jp;
        bs   = (c == 0) ? 2 : 3;
        cmax = (c == 0) ? 65535 : 15;
        if (c == 0) begin
          a_v = int'(bus2.o_stage_valid); a_sel = int'(bus2.o_pc_sel); a_fl = int'(bus2.o_flush);
          a_fa = int'(bus2.o_fwd_a); a_fb = int'(bus2.o_fwd_b);
          a_sc = int'(bus2.o_stall_cnt); a_fc = int'(bus2.o_flush_cnt); a_rc = int'(bus2.o_retired_cnt);
        end else begin
          a_v = int'(bus3.o_stage_valid); a_sel = int'(bus3.o_pc_sel); a_fl = int'(bus3.o_flush);
          a_fa = int'(bus3.o_fwd_a); a_fb = int'(bus3.o_fwd_b);
          a_sc = int'(bus3.o_stall_cnt); a_fc = int'(bus3.o_flush_cnt); a_rc = int'(bus3.o_retired_cnt);
        end
        lu = (mv[c][0] != 0) && (mv[c][1] != 0) && x.ex_mr && (x.ex_rd != 5'd0) &&
             ((x.uses_rs && x.id_rs == x.ex_rd) || (x.uses_rt && x.id_rt == x.ex_rd));
        br = (mv[c][bs-1] != 0) && x.taken;
        jp = (mv[c][0] != 0) && x.jump && !lu;
        e_sel = 0; e_fl = 0; e_st = 0;
        if (br) begin
          e_sel = 2; e_fl = (1 << bs) - 1;
        end else if (lu) begin
          e_st = 7;
        end else if (jp) begin
          e_sel = 1; e_fl = 1;
        end
        chk($sformatf("rnd%0d c%0d valid", bs, cyc), a_v, mv[c][3]*8 + mv[c][2]*4 + mv[c][1]*2 + mv[c][0]);
        chk($sformatf("rnd%0d c%0d pc_sel", bs, cyc), a_sel, e_sel);
        chk($sformatf("rnd%0d c%0d flush", bs, cyc), a_fl, e_fl);
        chk($sformatf("rnd%0d c%0d stall", bs, cyc), stall3(c), e_st);
        chk($sformatf("rnd%0d c%0d fwd_a", bs, cyc), a_fa, fwd_model(c, x.ex_rs, x));
        chk($sformatf("rnd%0d c%0d fwd_b", bs, cyc), a_fb, fwd_model(c, x.ex_rt, x));
        chk($sformatf("rnd%0d c%0d stall_cnt", bs, cyc), a_sc, msc[c]);
        chk($sformatf("rnd%0d c%0d flush_cnt", bs, cyc), a_fc, mfc[c]);
        chk($sformatf("rnd%0d c%0d retired_cnt", bs, cyc), a_rc, mrc[c]);
        // Instruction movement: a branch kills everything younger than itself,
        // a jump kills IF/ID, a load-use holds IF/ID and inserts a bubble.
        nv[c][3] = mv[c][2];
        nv[c][2] = (br && bs == 3) ? 0 : mv[c][1];
        nv[c][1] = (br || jp || lu) ? 0 : mv[c][0];
        nv[c][0] = (br || jp) ? 0 : (lu ? mv[c][0] : int'(x.fv));
        if (x.clr) begin
          msc[c] = 0; mfc[c] = 0; mrc[c] = 0;
        end else begin
          if (lu && !br && msc[c] < cmax) msc[c]++;
          if ((br || jp) && mfc[c] < cmax) mfc[c]++;
          if (mv[c][3] != 0 && mrc[c] < cmax) mrc[c]++;
        end
      end
      tick();
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 4; k++) mv[c][k] = nv[c][k];
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and pipeline-validity controller for the five-stage MIPS pipeline (IF, ID, EX, DM, WB). It tracks a valid bit for each inter-stage register and detects load-use hazards, producing stall/bubble controls. It produces flushes for jumps resolved in ID and branches resolved at a configurable stage, generates EX-stage forwarding selects, and keeps saturating performance counters. It sits beside the stage registers and replaces the ad-hoc counter signalling between the instruction memory, control unit and EX.

## Interface
- REG_ADDR_W, 5: register address width.
- BRANCH_STAGE, 2: register whose instruction resolves branches; 2 = ID/EX (resolved in EX), 3 = EX/DM (resolved in DM). Other values illegal.
- CNT_W, 16: performance counter width.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- fetch_valid  in  1  IF presents a real instruction this cycle.
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in IF/ID.
- id_uses_rs, id_uses_rt  in  1  source actually read.
- id_jump  in  1  IF/ID instruction is a jump.
- ex_rs, ex_rt  in  REG_ADDR_W  sources of the instruction in ID/EX.
- ex_rd, ex_reg_write, ex_mem_read  in  REG_ADDR_W/1/1  destination info from ID/EX.
- dm_rd, dm_reg_write  in  REG_ADDR_W/1  from EX/DM.
- wb_rd, wb_reg_write  in  REG_ADDR_W/1  from DM/WB.
- branch_taken  in  1  branch in register BRANCH_STAGE is taken.
- cnt_clr  in  1  synchronous clear of counters.
- stage_valid  out  4  valid bits [0]=IF/ID, [1]=ID/EX, [2]=EX/DM, [3]=DM/WB.
- pc_stall, if_id_stall  out  1  hold PC / IF/ID.
- id_ex_bubble  out  1  load zero controls into ID/EX.
- flush  out  4  per-register flush, same bit order as stage_valid.
- pc_sel  out  2  00 PC+4, 01 jump target, 10 branch target.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 10 EX/DM result, 01 DM/WB result.
- stall_cnt, flush_cnt, retired_cnt  out  CNT_W  performance counters.

## Operation
- v[i] = stage_valid[i]. Qualified writers: EXw = v[1]&ex_reg_write&ex_rd!=0; DMw = v[2]&dm_reg_write&dm_rd!=0; WBw = v[3]&wb_reg_write&wb_rd!=0.
- Load-use: lu = v[0] & v[1] & ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Branch: br = v[BRANCH_STAGE-1] & branch_taken. Jump: jp = v[0] & id_jump & !lu.
- Priority: br > lu > jp.
- br: pc_sel=10; flush[k]=1 for all k < BRANCH_STAGE; no stall. The branch itself advances normally.
- lu & !br: pc_stall=if_id_stall=id_ex_bubble=1.
- jp & !br: pc_sel=01; flush[0]=1.
- Otherwise, pc_sel=00 and all controls are 0.
- Valid update per clock:
  - v[3]<=v[2]; v[2]<=v[1] & !flush[1]; v[1]<=v[0] & !flush[0] & !lu.
  - Under br, v[1]<=0 when BRANCH_STAGE=3; v[2]<=v[1] when BRANCH_STAGE=2, because the branch advances.
  - v[0]<= flush[0] ? 0 : (lu ? v[0] : fetch_valid).
- Forwarding, EX operand A (B identical with ex_rt): 10 if EXw-source DMw & dm_rd==ex_rs, else 01 if WBw & wb_rd==ex_rs, else 00. EX/DM wins over DM/WB. Register 0 is never forwarded.
- Counters: stall_cnt += lu&!br; flush_cnt += (br|jp); retired_cnt += v[3]. All saturate at all-ones. cnt_clr zeroes them and takes precedence over increment.

## Timing
- Reset values: stage_valid=0, all counters 0; combinational outputs are therefore 00/0.
- Hazard, flush, pc_sel and forwarding outputs are combinational from inputs and the registered v. They settle in the same cycle and are sampled by the stage registers at the next edge.
- Load-use costs exactly one bubble. The cycle after the stall, the load is in EX/DM and the dependent instruction takes fwd=01 from DM/WB the following cycle.
- Branch penalty is BRANCH_STAGE cycles; jump penalty is 1 cycle.
- A jump held in IF/ID during a stall is re-evaluated after the stall; exactly one jump redirect occurs.
- An empty pipeline (all v=0) never stalls, flushes or forwards, regardless of stale register fields.
- Reset asserted mid-operation clears v and counters immediately, independent of clk. The first fetch_valid after release enters v[0] at the next edge.

## Test plan
- Reset mid-run with v=1111 and counters nonzero -> all outputs 0 immediately; after release, 4 cycles of fetch_valid -> v=1111.
- lw $2 in ID/EX, add using $2 in IF/ID -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1, stall_cnt=1, then fwd_a=01 for the add in EX.
- add $3 in EX/DM, add $3 in DM/WB, sub reading $3 in EX -> fwd_a=10; same pattern with rd=0 -> fwd_a=00.
- BRANCH_STAGE=2, taken branch -> pc_sel=10, flush=0011, flush_cnt=1; BRANCH_STAGE=3 -> flush=0111.
- Taken branch and load-use in the same cycle -> flush only, stall_cnt unchanged. Jump in IF/ID during a load-use -> stall first, then pc_sel=01 and flush=0001 the next cycle.
- CNT_W=4 with 20 retirements -> retired_cnt=15. cnt_clr concurrent with a retirement -> counter 0.
